wash_cycle_ctrl: RTL and testbench
==================================

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the phase timer.
REQ-002 Parameter FILL_T, default 20, FILL duration in ticks; range 1..2^CNT_W-1 (same range for all *_T).
REQ-003 Parameter WASH_T, default 60, WASH duration in ticks.
REQ-004 Parameter RINSE_T, default 40, RINSE duration in ticks.
REQ-005 Parameter DRAIN_T, default 15, DRAIN duration in ticks.
REQ-006 Parameter SPIN_T, default 30, SPIN duration in ticks.
REQ-007 Parameter MAX_RINSE, default 3, upper clamp for requested rinse count.
REQ-008 clk  in  1  clock.
REQ-009 reset  in  1  reset, asynchronous, active-high.
REQ-010 tick  in  1  single-cycle timebase enable; timers advance only on tick.
REQ-011 start  in  1  level; requests a cycle when IDLE.
REQ-012 abort  in  1  level; terminates any cycle.
REQ-013 door_open  in  1  door sensor, 1 = open.
REQ-014 rinse_cnt  in  3  number of rinse passes, sampled at start acceptance.
REQ-015 water, agitator, motor, pump, speed  out  1 each  actuator drives.
REQ-016 hold  out  1  door-interlock pause active.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on normal cycle completion.
REQ-019 state_o  out  3  current state encoding.

Function
REQ-020 States: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, HOLD=6; outputs decoded from the state register only (Moore).
REQ-021 Outputs per state: FILL water; WASH/RINSE agitator+motor; DRAIN pump; SPIN motor+speed; HOLD hold; IDLE all 0.
REQ-022 IDLE->FILL on clock edge with start=1, door_open=0, abort=0; start with door open is ignored; start while busy is ignored.
REQ-023 At acceptance: rinse_left <= min(rinse_cnt, MAX_RINSE); washed <= 0.
REQ-024 On every state entry (except HOLD return) timer loads that state's duration; it decrements on each tick; phase ends on the edge where tick=1 and timer=1, so each phase lasts exactly *_T ticks.
REQ-025 Sequence: FILL->WASH if washed=0, else FILL->RINSE; WASH->DRAIN, sets washed=1; RINSE->DRAIN, decrements rinse_left.
REQ-026 DRAIN->FILL if rinse_left>0, else DRAIN->SPIN; SPIN->IDLE with done=1 in the first IDLE cycle.
REQ-027 rinse_cnt=0: FILL, WASH, DRAIN, SPIN only.
REQ-028 door_open=1 in any busy state other than HOLD: next edge enters HOLD, saves return state, freezes timer.
REQ-029 HOLD->saved state when door_open=0; timer resumes from frozen value, no reload, no tick lost or added.
REQ-030 abort=1 in any state, HOLD included: next edge -> IDLE, no done pulse, rinse_left cleared; abort has priority over door_open and phase end.
REQ-031 Phase end and door_open on the same edge: door wins; HOLD returns to the old state with timer=1 pending.
REQ-032 tick=0 indefinitely: state holds; outputs stable.

Reset
REQ-033 reset=1: state IDLE, all outputs 0, timer 0, rinse_left 0, washed 0, saved state IDLE, applied asynchronously.
REQ-034 Reset mid-cycle: identical to REQ-033; no done pulse; first start after deassertion begins a fresh cycle.

Structure
REQ-035 Package washer_pkg holds the state encoding constants and default duration constants.
REQ-036 Sub-module phase_timer (CNT_W down-counter with load, tick enable, freeze, expire flag) is instantiated once.

Verification
REQ-037 FILL_T=3, WASH_T=4, RINSE_T=2, DRAIN_T=2, SPIN_T=5, tick=1, rinse_cnt=1, start -> states F,W,D,F,R,D,S each for its duration; done 21 cycles after FILL entry.
REQ-038 Same params, rinse_cnt=7, MAX_RINSE=3 -> exactly 3 RINSE phases; done after 3+4+2+3×(3+2+2)+5=35 cycles.
REQ-039 door_open pulsed 4 cycles in mid-SPIN with 2 ticks left -> HOLD for 4 cycles, all actuators 0, then SPIN runs 2 more ticks.
REQ-040 abort in RINSE -> IDLE next edge, busy=0, done never asserted; start with door_open=1 -> stays IDLE.
REQ-041 tick every 4th cycle, rinse_cnt=0 -> phase lengths scale ×4; reset asserted in WASH -> immediate IDLE, outputs 0.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared constants for the wash-cycle controller: state codes, default phase
// lengths and the rinse-count clamp.
package washer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RINSE = 3'd4;
    localparam logic [2:0] S_SPIN  = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;

    localparam int unsigned FILL_T_DEF    = 20;
    localparam int unsigned WASH_T_DEF    = 60;
    localparam int unsigned RINSE_T_DEF   = 40;
    localparam int unsigned DRAIN_T_DEF   = 15;
    localparam int unsigned SPIN_T_DEF    = 30;
    localparam int unsigned MAX_RINSE_DEF = 3;

    function automatic logic [2:0] clamp_rinse(input logic [2:0] req, input logic [2:0] cap);
        return (req > cap) ? cap : req;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: load wins over everything, freeze holds the count,
// otherwise it decrements on each tick. Expiry flags the last tick of a phase.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             freeze_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!freeze_i && tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Not gated by freeze, so the controller decides whether door or expiry wins.
    assign expire_o = tick_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: FILL/WASH/DRAIN, optional rinse passes,
// SPIN, with a door-interlock HOLD that freezes the phase timer.
module wash_cycle_ctrl
    import washer_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FILL_T    = FILL_T_DEF,
    parameter int unsigned WASH_T    = WASH_T_DEF,
    parameter int unsigned RINSE_T   = RINSE_T_DEF,
    parameter int unsigned DRAIN_T   = DRAIN_T_DEF,
    parameter int unsigned SPIN_T    = SPIN_T_DEF,
    parameter int unsigned MAX_RINSE = MAX_RINSE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       door_open,
    input  logic [2:0] rinse_cnt,
    output logic       water,
    output logic       agitator,
    output logic       motor,
    output logic       pump,
    output logic       speed,
    output logic       hold,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] FILL_LD   = CNT_W'(FILL_T);
    localparam logic [CNT_W-1:0] WASH_LD   = CNT_W'(WASH_T);
    localparam logic [CNT_W-1:0] RINSE_LD  = CNT_W'(RINSE_T);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_T);
    localparam logic [CNT_W-1:0] SPIN_LD   = CNT_W'(SPIN_T);
    localparam logic [2:0]       RINSE_CAP = (MAX_RINSE > 7) ? 3'd7 : 3'(MAX_RINSE);

    logic [2:0]       state_q, state_d;
    logic [2:0]       ret_q, ret_d;
    logic [2:0]       rinse_left_q, rinse_left_d;
    logic             washed_q, washed_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_freeze;
    logic             tmr_expire;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .freeze_i   (tmr_freeze),
        .expire_o   (tmr_expire)
    );

    // Priority: abort, then door interlock, then phase expiry.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        rinse_left_d = rinse_left_q;
        washed_d     = washed_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_freeze   = 1'b0;
        if (abort) begin
            state_d      = S_IDLE;
            ret_d        = S_IDLE;
            rinse_left_d = '0;
            washed_d     = 1'b0;
            tmr_load     = 1'b1;
        end else if (state_q == S_IDLE) begin
            if (start && !door_open) begin
                state_d      = S_FILL;
                rinse_left_d = clamp_rinse(rinse_cnt, RINSE_CAP);
                washed_d     = 1'b0;
                tmr_load     = 1'b1;
                tmr_load_val = FILL_LD;
            end
        end else if (state_q == S_HOLD) begin
            tmr_freeze = 1'b1;
            if (!door_open) begin
                state_d = ret_q;
            end
        end else if (door_open) begin
            state_d    = S_HOLD;
            ret_d      = state_q;
            tmr_freeze = 1'b1;
        end else if (tmr_expire) begin
            tmr_load = 1'b1;
            case (state_q)
                S_FILL: begin
                    state_d      = washed_q ? S_RINSE : S_WASH;
                    tmr_load_val = washed_q ? RINSE_LD : WASH_LD;
                end
                S_WASH: begin
                    state_d      = S_DRAIN;
                    washed_d     = 1'b1;
                    tmr_load_val = DRAIN_LD;
                end
                S_RINSE: begin
                    state_d      = S_DRAIN;
                    rinse_left_d = rinse_left_q - 3'd1;
                    tmr_load_val = DRAIN_LD;
                end
                S_DRAIN: begin
                    state_d      = (rinse_left_q != '0) ? S_FILL : S_SPIN;
                    tmr_load_val = (rinse_left_q != '0) ? FILL_LD : SPIN_LD;
                end
                S_SPIN: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            rinse_left_q <= '0;
            washed_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            rinse_left_q <= rinse_left_d;
            washed_q     <= washed_d;
            done_q       <= done_d;
        end
    end

    assign water    = (state_q == S_FILL);
    assign agitator = (state_q == S_WASH) || (state_q == S_RINSE);
    assign motor    = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
    assign pump     = (state_q == S_DRAIN);
    assign speed    = (state_q == S_SPIN);
    assign hold     = (state_q == S_HOLD);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: hand vectors, directed multi-cycle
// sequences and random stimulus against a phase-schedule reference model.
module tb_wash_cycle_ctrl;

    localparam int P_FILL  = 3;
    localparam int P_WASH  = 4;
    localparam int P_RINSE = 2;
    localparam int P_DRAIN = 2;
    localparam int P_SPIN  = 5;
    localparam int P_MAXR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, start = 1'b0, abort = 1'b0, door_open = 1'b0;
    logic [2:0] rinse_cnt = 3'd0;
    logic       water, agitator, motor, pump, speed, hold, busy, done;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    wash_cycle_ctrl #(
        .CNT_W(8), .FILL_T(P_FILL), .WASH_T(P_WASH), .RINSE_T(P_RINSE),
        .DRAIN_T(P_DRAIN), .SPIN_T(P_SPIN), .MAX_RINSE(P_MAXR)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .door_open(door_open), .rinse_cnt(rinse_cnt), .water(water),
        .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
        .hold(hold), .busy(busy), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: a cycle is a list of (phase, length) entries consumed by ticks.
    int sch_code[16];
    int sch_len[16];
    int sch_n, sch_i, m_rem;
    bit m_busy, m_hold, m_done;

    function automatic void model_clear();
        m_busy = 0; m_hold = 0; m_done = 0; sch_n = 0; sch_i = 0; m_rem = 0;
    endfunction

    function automatic void push(int code, int len);
        sch_code[sch_n] = code;
        sch_len[sch_n]  = len;
        sch_n++;
    endfunction

    function automatic void model_start(int rc);
        int r;
        r = (rc > P_MAXR) ? P_MAXR : rc;
        sch_n = 0;
        push(1, P_FILL); push(2, P_WASH); push(3, P_DRAIN);
        for (int k = 0; k < r; k++) begin
            push(1, P_FILL); push(4, P_RINSE); push(3, P_DRAIN);
        end
        push(5, P_SPIN);
        sch_i = 0; m_rem = sch_len[0]; m_busy = 1; m_hold = 0;
    endfunction

    function automatic void model_edge(bit st, bit ab, bit dr, bit tk, int rc);
        m_done = 0;
        if (ab) begin
            model_clear();
        end else if (!m_busy) begin
            if (st && !dr) model_start(rc);
        end else if (m_hold) begin
            if (!dr) m_hold = 0;
        end else if (dr) begin
            m_hold = 1;
        end else if (tk) begin
            m_rem--;
            if (m_rem == 0) begin
                sch_i++;
                if (sch_i == sch_n) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_rem = sch_len[sch_i];
                end
            end
        end
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [2:0] s;
        logic [4:0] act;
        s = !m_busy ? 3'd0 : (m_hold ? 3'd6 : 3'(sch_code[sch_i]));
        case (s)
            3'd1:       act = 5'b10000;
            3'd2, 3'd4: act = 5'b01100;
            3'd3:       act = 5'b00010;
            3'd5:       act = 5'b00101;
            default:    act = 5'b00000;
        endcase
        return {s, act, (s == 3'd6), (s != 3'd0), m_done};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {state_o, water, agitator, motor, pump, speed, hold, busy, done};
    endfunction

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endfunction

    task automatic cyc(input bit st, input bit ab, input bit dr, input bit tk, input logic [2:0] rc);
        start = st; abort = ab; door_open = dr; tick = tk; rinse_cnt = rc;
        model_edge(st, ab, dr, tk, int'(rc));
        @(posedge clk);
        #1;
        cyc_no++;
        check("cycle_outputs", int'(dut_vec()), int'(exp_vec()));
    endtask

    task automatic run_to(input logic [2:0] code, input int budget);
        int n;
        n = 0;
        while (state_o !== code && n < budget) begin
            cyc(0, 0, 0, 1, 3'd0);
            n++;
        end
        if (state_o !== code) check("run_to_timeout", int'(state_o), int'(code));
    endtask

    task automatic run_cycle(input logic [2:0] rc, input int period, output int n, output int rinses);
        logic [2:0] prev;
        n = 0; rinses = 0;
        cyc(1, 0, 0, 1, rc);
        prev = state_o;
        while (done !== 1'b1 && n < 400) begin
            cyc(0, 0, 0, ((n % period) == period - 1), 3'd0);
            n++;
            if (state_o == 3'd4 && prev != 3'd4) rinses++;
            prev = state_o;
        end
    endtask

    typedef struct packed {
        logic       st;
        logic       ab;
        logic       dr;
        logic       tk;
        logic [2:0] rc;
        logic [2:0] exp_state;
        logic       exp_done;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, hold_cnt, spin_cnt;
        bit door_r;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd6, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd6, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'(dut_vec()), 0);
        reset = 1'b0;
        cyc(0, 0, 0, 1, 3'd0);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].dr, tbl[i].tk, tbl[i].rc);
            check("vec_state", int'(state_o), int'(tbl[i].exp_state));
            check("vec_done", int'(done), int'(tbl[i].exp_done));
            check("vec_busy", int'(busy), int'(tbl[i].exp_state != 3'd0));
            $display("vec %0d: state=%0d done=%0d busy=%0d", i, state_o, done, busy);
        end

        run_cycle(3'd1, 1, n, r);
        check("done_latency_r1", n, 21);
        check("rinse_phases_r1", r, 1);
        $display("seq rinse1: done after %0d cycles, %0d rinse phases", n, r);

        run_cycle(3'd7, 1, n, r);
        check("done_latency_r7", n, 35);
        check("rinse_phases_r7", r, 3);
        $display("seq rinse7: done after %0d cycles, %0d rinse phases", n, r);

        cyc(1, 0, 0, 1, 3'd0);
        run_to(3'd5, 100);
        repeat (3) cyc(0, 0, 0, 1, 3'd0);
        hold_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 1, 3'd0);
            if (state_o == 3'd6) hold_cnt++;
            check("hold_actuators", int'({water, agitator, motor, pump, speed, hold}), 1);
        end
        check("hold_cycles", hold_cnt, 4);
        spin_cnt = 0;
        for (int k = 0; k < 10 && done !== 1'b1; k++) begin
            cyc(0, 0, 0, 1, 3'd0);
            if (state_o == 3'd5) spin_cnt++;
        end
        check("spin_after_hold", spin_cnt, 2);
        check("spin_done", int'(done), 1);
        $display("seq door: hold %0d cycles, spin %0d more ticks", hold_cnt, spin_cnt);

        cyc(1, 0, 0, 1, 3'd2);
        run_to(3'd4, 100);
        cyc(0, 1, 0, 1, 3'd0);
        check("abort_state", int'(state_o), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (3) cyc(0, 0, 0, 1, 3'd0);
        cyc(1, 0, 1, 1, 3'd3);
        check("start_door_open", int'(state_o), 0);
        $display("seq abort: state=%0d busy=%0d", state_o, busy);

        run_cycle(3'd0, 4, n, r);
        check("done_latency_tick4", n, 56);
        check("rinse_phases_tick4", r, 0);
        $display("seq tick/4: done after %0d cycles", n);

        cyc(1, 0, 0, 1, 3'd0);
        run_to(3'd2, 100);
        reset = 1'b1;
        #2;
        check("async_reset_outputs", int'(dut_vec()), 0);
        @(posedge clk);
        #1;
        check("reset_hold_outputs", int'(dut_vec()), 0);
        reset = 1'b0;
        model_clear();
        cyc(1, 0, 0, 1, 3'd0);
        check("fresh_start", int'(state_o), 1);
        $display("seq reset: state=%0d after restart", state_o);

        for (int ep = 0; ep < 6; ep++) begin
            cyc(0, 1, 0, 0, 3'd0);
            door_r = 0;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 15) == 0) door_r = ~door_r;
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0), door_r,
                    (ep % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
            end
            $display("random episode %0d: %0d checks so far, %0d failures", ep, n_checks, n_fail);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
